// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory responder
package mem_pkg;

    // Access width encoding carried on req_size
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_BAD  = 2'd3
    } mem_size_t;

    // Request sequencing: accept, optional wait states, one-cycle response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Wide enough for WAIT_STATES up to 15
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering between right-aligned CPU data and the memory word
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    // Read word moved down so the addressed byte sits in lane 0
    logic [31:0] w_rshift;
    assign w_rshift = i_rword >> {i_addr_lo, 3'b000};

    // Replicating the store data across lanes lets the byte enables alone pick the target bytes
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = 32'h0;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_size)
            MEM_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'h0, w_rshift[7:0]};
            end
            MEM_HALF: begin
                o_misalign = i_addr_lo[0];
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {16'h0, w_rshift[15:0]};
            end
            MEM_WORD: begin
                o_misalign = |i_addr_lo;
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_rword;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-addressed little-endian RAM servicing CPU load/store requests
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    mem_state_t              r_state;
    mem_state_t              w_next;
    logic [WAIT_CNT_W-1:0]   r_cnt;
    logic                    r_write;
    mem_size_t               r_size;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [7:0]              r_mem [DEPTH];

    logic                    w_ready;
    logic                    w_rsp;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic [31:0]             w_rword;
    logic [3:0]              w_be;
    logic [31:0]             w_lane_wdata;
    logic [31:0]             w_rdata;
    logic                    w_misalign;
    logic                    w_oor;
    logic                    w_err;

    // Reset masks the handshake and the response so an abandoned request never surfaces
    assign req_ready = w_ready && !reset;
    assign rsp_valid = w_rsp && !reset;
    assign busy      = (r_state != IDLE);
    assign w_accept  = req_valid && req_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_rsp   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (req_valid) begin
                    w_next = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_rsp  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Wait-state counter: loaded on accept, counts down while waiting
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Request capture so the requester is free once accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            r_write <= 1'b0;
            r_size  <= MEM_BYTE;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_size  <= mem_size_t'(req_size);
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Accesses never cross a word, so all four lanes come from one aligned word
    assign w_base = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    // Assemble the addressed word little-endian from the byte array
    always_comb begin
        w_rword = 32'h0;
        for (int i = 0; i < 4; i++) begin
            w_rword[8*i +: 8] = r_mem[w_base | ADDR_WIDTH'(i)];
        end
    end

    mem_lane_align u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_lane_wdata),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign)
    );

    // Addresses beyond the implemented space are rejected rather than wrapped
    assign w_oor = (r_addr >> ADDR_WIDTH) != 32'h0;
    assign w_err = (r_size == MEM_BAD) || w_misalign || w_oor;

    assign rsp_error = rsp_valid && w_err;
    assign rsp_rdata = (rsp_valid && !r_write && !w_err) ? w_rdata : 32'h0;

    // Store commits on the edge that ends the response cycle; storage itself is never reset
    always_ff @(posedge clock) begin
        if (!reset && w_rsp && r_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_base | ADDR_WIDTH'(i)] <= w_lane_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
